// File: rtl/eau_pipe_if.sv
// Operand bundle between the upstream vector source, the alignment pipeline and
// the lane-wise consumer. The master drives the request side; the slave is the pipeline.
interface eau_pipe_if #(
  parameter int VLEN = 256,
  parameter int BSW  = 5,
  parameter int NCH  = 2
);
  localparam int BS   = 1 << BSW;
  localparam int BLEN = VLEN / BS;
  localparam int WW   = 8 - BSW + 1;

  logic                             i_valid;
  logic                             i_ready;
  logic                             i_sext;
  logic [NCH-1:0][BSW:0]            inum;
  logic [NCH-1:0][BS-1:0][WW-1:0]   ilen;
  logic [NCH-1:0][BS-1:0][BSW-1:0]  ipos;
  logic [NCH-1:0][BS-1:0][BLEN-1:0] idata;
  logic                             o_valid;
  logic                             o_ready;
  logic [BSW:0]                     onum;
  logic [NCH-1:0][BS-1:0][BLEN-1:0] odata;

  modport master (
    output i_valid, i_sext, inum, ilen, ipos, idata, o_ready,
    input  i_ready, o_valid, onum, odata
  );

  modport slave (
    input  i_valid, i_sext, inum, ilen, ipos, idata, o_ready,
    output i_ready, o_valid, onum, odata
  );
endinterface

// File: rtl/eau_pipe.sv
// N-channel element alignment: widens element k to the longest length across channels
// and repacks every channel onto one shared chunk grid, in a 2-stage valid/ready pipe.
module eau_pipe #(
  parameter int VLEN = 256,
  parameter int BSW  = 5,
  parameter int NCH  = 2
) (
  input  logic      clk,
  input  logic      rst_n,
  eau_pipe_if.slave bus
);
  localparam int BS   = 1 << BSW;
  localparam int BLEN = VLEN / BS;
  localparam int WW   = 8 - BSW + 1;
  localparam int PW   = BSW + WW;
  localparam int NW   = BSW + 1;

  typedef logic [BS-1:0][BLEN-1:0] chan_t;

  if (((1 << WW) - 1) > BS) begin : g_len_chk
    $error("eau_pipe: length field range exceeds chunk slot count");
  end

  // Pad value source: MSB of the element's last chunk; missing chunk or empty element pads zero.
  function automatic logic pad_sign(input logic sext, input logic [WW-1:0] len,
                                    input logic [BSW-1:0] pos, input chan_t data);
    logic [NW-1:0] idx;
    idx = NW'(pos) + NW'(len) - NW'(1);
    if (!sext || len == '0 || idx >= NW'(BS)) return 1'b0;
    return data[idx[BSW-1:0]][BLEN-1];
  endfunction

  function automatic logic [BLEN-1:0] pick(input logic [PW-1:0] off, input logic [WW-1:0] len,
                                           input logic [BSW-1:0] pos, input logic sgn,
                                           input chan_t data);
    logic [NW-1:0] src;
    if (off >= PW'(len)) return sgn ? '1 : '0;
    src = NW'(pos) + NW'(off);
    if (src >= NW'(BS)) return '0;
    return data[src[BSW-1:0]];
  endfunction

  logic                             w_s1_adv;
  logic                             w_in_fire;
  logic [NW-1:0]                    w_n;
  logic [BS-1:0][WW-1:0]            w_len;
  logic [BS-1:0][PW-1:0]            w_pre;

  logic                             r_vld_p1;
  logic [NW-1:0]                    r_n_p1;
  logic [BS-1:0][WW-1:0]            r_len_p1;
  logic [BS-1:0][PW-1:0]            r_pre_p1;
  logic [NCH-1:0][BS-1:0][WW-1:0]   r_clen_p1;
  logic [NCH-1:0][BS-1:0][BSW-1:0]  r_pos_p1;
  logic [NCH-1:0][BS-1:0][BLEN-1:0] r_data_p1;
  logic                             r_sext_p1;

  logic [BS-1:0]                    w_emit;
  logic [NW-1:0]                    w_onum;
  logic [NCH-1:0][BS-1:0]           w_sgn;
  logic [NCH-1:0][BS-1:0][BLEN-1:0] w_odata;

  logic                             r_vld_p2;
  logic [NW-1:0]                    r_onum_p2;
  logic [NCH-1:0][BS-1:0][BLEN-1:0] r_odata_p2;

  assign w_s1_adv    = !r_vld_p2 || bus.o_ready;
  assign bus.i_ready = !r_vld_p1 || w_s1_adv;
  assign w_in_fire   = bus.i_valid && bus.i_ready;

  // Stage 0 -> 1: common element count, widened lengths and their start offsets
  always_comb begin
    logic [PW-1:0] acc;
    w_n = bus.inum[0];
    for (int c = 1; c < NCH; c++)
      if (bus.inum[c] < w_n) w_n = bus.inum[c];
    acc = '0;
    for (int k = 0; k < BS; k++) begin
      w_len[k] = bus.ilen[0][k];
      for (int c = 1; c < NCH; c++)
        if (bus.ilen[c][k] > w_len[k]) w_len[k] = bus.ilen[c][k];
      w_pre[k] = acc;
      acc      = acc + PW'(w_len[k]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (bus.i_ready) r_vld_p1 <= bus.i_valid;
      if (w_s1_adv)    r_vld_p2 <= r_vld_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_n_p1    <= w_n;
      r_len_p1  <= w_len;
      r_pre_p1  <= w_pre;
      r_clen_p1 <= bus.ilen;
      r_pos_p1  <= bus.ipos;
      r_data_p1 <= bus.idata;
      r_sext_p1 <= bus.i_sext;
    end
  end

  // Stage 1 -> 2: ends are non-decreasing, so the fitting elements always form a prefix
  always_comb begin
    w_onum = '0;
    for (int k = 0; k < BS; k++) begin
      w_emit[k] = (NW'(k) < r_n_p1) && ((r_pre_p1[k] + PW'(r_len_p1[k])) <= PW'(BS));
      w_onum    = w_onum + NW'(w_emit[k]);
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < BS; k++)
        w_sgn[c][k] = pad_sign(r_sext_p1, r_clen_p1[c][k], r_pos_p1[c][k], r_data_p1[c]);
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      for (int j = 0; j < BS; j++) begin
        w_odata[c][j] = '0;
        for (int k = 0; k < BS; k++)
          if (w_emit[k] && (PW'(j) >= r_pre_p1[k]) &&
              (PW'(j) < r_pre_p1[k] + PW'(r_len_p1[k])))
            w_odata[c][j] = pick(PW'(j) - r_pre_p1[k], r_clen_p1[c][k], r_pos_p1[c][k],
                                 w_sgn[c][k], r_data_p1[c]);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_onum_p2  <= '0;
      r_odata_p2 <= '0;
    end else if (w_s1_adv && r_vld_p1) begin
      r_onum_p2  <= w_onum;
      r_odata_p2 <= w_odata;
    end
  end

  assign bus.o_valid = r_vld_p2;
  assign bus.onum    = r_onum_p2;
  assign bus.odata   = r_odata_p2;
endmodule

// File: tb/tb_eau_pipe.sv
// Directed bench for eau_pipe: alignment, padding, element count, stalls and async reset.
module tb_eau_pipe;
  localparam int VLEN = 256;
  localparam int BSW  = 5;
  localparam int NCH  = 2;
  localparam int BS   = 32;
  localparam int BLEN = 8;
  localparam int OW   = NCH * BS * BLEN;

  typedef logic [NCH-1:0][BS-1:0][BLEN-1:0] dat_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  eau_pipe_if #(.VLEN(VLEN), .BSW(BSW), .NCH(NCH)) bus ();

  eau_pipe #(.VLEN(VLEN), .BSW(BSW), .NCH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.i_valid = 1'b0;
    bus.i_sext  = 1'b0;
    bus.inum    = '0;
    bus.ilen    = '0;
    bus.ipos    = '0;
    bus.idata   = '0;
  endtask

  task automatic set_ident(input int base, input int n);
    for (int c = 0; c < NCH; c++) begin
      bus.inum[c] = 6'(n);
      for (int k = 0; k < BS; k++) begin
        bus.ilen[c][k]  = 4'd1;
        bus.ipos[c][k]  = 5'(k);
        bus.idata[c][k] = 8'(k + 16 * c + base);
      end
    end
  endtask

  function automatic dat_t exp_ident(input int base, input int n);
    dat_t e = '0;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < BS; k++)
        if (k < n) e[c][k] = 8'(k + 16 * c + base);
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    dat_t e;
    int   sent, recv, stall_cyc;

    clear_in();
    bus.o_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    chk("rst_o_valid", OW'(bus.o_valid), OW'(0));
    chk("rst_onum",    OW'(bus.onum),    OW'(0));
    chk("rst_odata",   bus.odata,        OW'(0));
    chk("rst_i_ready", OW'(bus.i_ready), OW'(1));
    @(negedge clk) rst_n = 1'b1;
    step();

    // identity vector, full count
    set_ident(0, 32);
    bus.i_valid = 1'b1;
    #1 chk("t1_i_ready", OW'(bus.i_ready), OW'(1));
    step();
    bus.i_valid = 1'b0;
    #1 chk("t1_lat1_valid", OW'(bus.o_valid), OW'(0));
    step();
    #1;
    chk("t1_valid", OW'(bus.o_valid), OW'(1));
    chk("t1_onum",  OW'(bus.onum),    OW'(32));
    chk("t1_data",  bus.odata,        exp_ident(0, 32));
    step();
    #1 chk("t1_drained", OW'(bus.o_valid), OW'(0));
    step();

    // sign / zero padding of a short element
    for (int s = 1; s >= 0; s--) begin
      clear_in();
      bus.inum        = {6'd1, 6'd1};
      bus.ilen[0][0]  = 4'd1;
      bus.ilen[1][0]  = 4'd2;
      bus.idata[0][0] = 8'h80;
      bus.idata[0][1] = 8'h55;
      bus.idata[1][0] = 8'h11;
      bus.idata[1][1] = 8'h22;
      bus.idata[1][2] = 8'h33;
      bus.i_sext      = s[0];
      bus.i_valid     = 1'b1;
      step();
      bus.i_valid = 1'b0;
      step();
      #1;
      e = '0;
      e[0][0] = 8'h80;
      e[0][1] = s[0] ? 8'hFF : 8'h00;
      e[1][0] = 8'h11;
      e[1][1] = 8'h22;
      chk(s[0] ? "t2_sext_onum" : "t2_zext_onum", OW'(bus.onum), OW'(1));
      chk(s[0] ? "t2_sext_data" : "t2_zext_data", bus.odata, e);
      step();
    end

    // empty element pads zero despite sext; zero-length element still counts
    clear_in();
    bus.inum        = {6'd2, 6'd2};
    bus.ilen[1][0]  = 4'd2;
    bus.idata[0][0] = 8'hFF;
    bus.idata[1][0] = 8'hF0;
    bus.idata[1][1] = 8'hF1;
    bus.i_sext      = 1'b1;
    bus.i_valid     = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step();
    #1;
    e = '0;
    e[1][0] = 8'hF0;
    e[1][1] = 8'hF1;
    chk("t2z_onum", OW'(bus.onum), OW'(2));
    chk("t2z_data", bus.odata,     e);
    step();

    // source running past the last chunk reads zero
    clear_in();
    bus.inum         = {6'd1, 6'd1};
    bus.ilen[0][0]   = 4'd2;
    bus.ipos[0][0]   = 5'd31;
    bus.idata[0][31] = 8'hA5;
    bus.idata[0][0]  = 8'h77;
    bus.ilen[1][0]   = 4'd3;
    bus.ipos[1][0]   = 5'd4;
    bus.idata[1][4]  = 8'h01;
    bus.idata[1][5]  = 8'h02;
    bus.idata[1][6]  = 8'h03;
    bus.i_valid      = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step();
    #1;
    e = '0;
    e[0][0] = 8'hA5;
    e[1][0] = 8'h01;
    e[1][1] = 8'h02;
    e[1][2] = 8'h03;
    chk("t2b_onum", OW'(bus.onum), OW'(1));
    chk("t2b_data", bus.odata,     e);
    step();

    // element count limited by space, then by inum
    for (int pass = 0; pass < 2; pass++) begin
      clear_in();
      bus.inum[0] = (pass == 0) ? 6'd20 : 6'd10;
      bus.inum[1] = 6'd25;
      for (int k = 0; k < BS; k++) begin
        bus.ilen[0][k] = 4'd2;
        bus.ilen[1][k] = 4'd2;
        bus.ipos[0][k] = 5'(2 * k);
        bus.ipos[1][k] = (k < 16) ? 5'(30 - 2 * k) : 5'd0;
        bus.idata[0][k] = 8'(3 * k);
        bus.idata[1][k] = 8'(3 * k + 100);
      end
      bus.i_valid = 1'b1;
      step();
      bus.i_valid = 1'b0;
      step();
      #1;
      e = '0;
      for (int j = 0; j < ((pass == 0) ? 32 : 20); j++) begin
        e[0][j] = 8'(3 * j);
        e[1][j] = 8'(3 * (30 - 2 * (j / 2) + (j % 2)) + 100);
      end
      chk(pass == 0 ? "t3_fit_onum" : "t3_n_onum", OW'(bus.onum), OW'((pass == 0) ? 16 : 10));
      chk(pass == 0 ? "t3_fit_data" : "t3_n_data", bus.odata, e);
      step();
    end

    // four back-to-back transactions against a 3-cycle output stall
    clear_in();
    sent = 0;
    recv = 0;
    stall_cyc = -1;
    for (int cyc = 0; cyc < 20 && recv < 4; cyc++) begin
      bus.o_ready = (cyc >= 3);
      if (sent < 4) begin
        set_ident(64 * sent, sent + 1);
        bus.i_valid = 1'b1;
      end else begin
        bus.i_valid = 1'b0;
      end
      #1;
      if (bus.i_valid && !bus.i_ready && stall_cyc < 0) stall_cyc = cyc;
      if (bus.o_valid) begin
        chk("t4_onum", OW'(bus.onum), OW'(recv + 1));
        chk("t4_data", bus.odata,     exp_ident(64 * recv, recv + 1));
        if (bus.o_ready) recv++;
      end
      if (bus.i_valid && bus.i_ready) sent++;
      step();
    end
    bus.i_valid = 1'b0;
    chk("t4_stall_cyc", OW'(stall_cyc), OW'(2));
    chk("t4_sent",      OW'(sent),      OW'(4));
    chk("t4_recv",      OW'(recv),      OW'(4));
    #1 chk("t4_no_dup", OW'(bus.o_valid), OW'(0));
    step();

    // asynchronous reset while a result is held
    clear_in();
    bus.o_ready = 1'b0;
    set_ident(0, 32);
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step();
    #2 chk("t5_pre_valid", OW'(bus.o_valid), OW'(1));
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", OW'(bus.o_valid), OW'(0));
    chk("t5_rst_onum",  OW'(bus.onum),    OW'(0));
    chk("t5_rst_data",  bus.odata,        OW'(0));
    #1;
    rst_n = 1'b1;
    bus.o_ready = 1'b1;
    step();
    set_ident(5, 7);
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    #1 chk("t5_lat1_valid", OW'(bus.o_valid), OW'(0));
    step();
    #1;
    chk("t5_valid", OW'(bus.o_valid), OW'(1));
    chk("t5_onum",  OW'(bus.onum),    OW'(7));
    chk("t5_data",  bus.odata,        exp_ident(5, 7));
    step();

    // one channel with no elements
    clear_in();
    set_ident(9, 0);
    bus.inum[1] = 6'd7;
    bus.i_valid = 1'b1;
    step();
    bus.i_valid = 1'b0;
    step();
    #1;
    chk("t6_valid", OW'(bus.o_valid), OW'(1));
    chk("t6_onum",  OW'(bus.onum),    OW'(0));
    chk("t6_data",  bus.odata,        OW'(0));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
